// File: rtl/gcd_requester.sv
// Request-side driver for the gcd start/done engine. It buffers operand pairs in a FIFO,
// runs one engine transaction at a time, and returns each result in request order.
module gcd_requester #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic [WIDTH-1:0] eng_result,
  input  logic             eng_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_a,
  output logic [WIDTH-1:0] rsp_b,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             push, pop, fifo_empty, tmo_hit, head_zero;
  logic [WIDTH-1:0] head_a, head_b;

  // Pops only happen from IDLE and only on registered non-empty, so a push into an
  // empty FIFO is never popped in the same cycle.
  assign fifo_empty = (count_q == '0);
  assign push       = req_valid && req_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head_a     = mem_a_q[rd_ptr_q];
  assign head_b     = mem_b_q[rd_ptr_q];
  assign head_zero  = (head_a == '0) || (head_b == '0);
  assign tmo_hit    = (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= req_a;
      mem_b_q[wr_ptr_q] <= req_b;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = head_zero ? RESPOND : ISSUE;
      ISSUE:     state_d = WAIT_LOW;
      WAIT_LOW:  if (tmo_hit) state_d = RESPOND;
                 else if (!eng_done) state_d = WAIT_HIGH;
      WAIT_HIGH: if (eng_done || tmo_hit) state_d = RESPOND;
      RESPOND:   if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    eng_start = (state_q == ISSUE);
    rsp_valid = (state_q == RESPOND);
    busy      = (state_q != IDLE) || !fifo_empty;
    req_ready = (count_q != CW'(DEPTH));
  end

  // Operand, result and timeout registers; a completion in the last allowed cycle wins
  always_comb begin
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
    case (state_q)
      IDLE: if (pop) begin
        op_a_d        = head_a;
        op_b_d        = head_b;
        rsp_timeout_d = 1'b0;
        rsp_result_d  = head_zero ? (head_a | head_b) : '0;
      end
      ISSUE: tmo_cnt_d = '0;
      WAIT_LOW: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (tmo_hit) begin
          rsp_timeout_d = 1'b1;
          rsp_result_d  = '0;
        end
      end
      WAIT_HIGH: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (eng_done) begin
          rsp_result_d = eng_result;
        end else if (tmo_hit) begin
          rsp_timeout_d = 1'b1;
          rsp_result_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign eng_a       = op_a_q;
  assign eng_b       = op_b_q;
  assign rsp_a       = op_a_q;
  assign rsp_b       = op_b_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural gcd engine whose done timing is
// selectable: normal, stale-done, or never-done.
module tb_gcd_requester;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic         eng_start;
  logic [W-1:0] eng_a, eng_b;
  logic [W-1:0] eng_result = '0;
  logic         eng_done = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result, rsp_a, rsp_b;
  logic         rsp_timeout;
  logic         busy;

  gcd_requester #(.WIDTH(W), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_result(eng_result), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p, q, t;
    p = x; q = y;
    while (q != 0) begin
      t = p % q; p = q; q = t;
    end
    return p;
  endfunction

  // Engine: mode 0 = done 3 cycles after start, mode 1 = stale done dropped late then
  // raised with 7, mode 2 = never completes.
  int mode = 0;
  int k = 0;
  logic [W-1:0] ea = '0, eb = '0;
  always @(posedge clk) begin
    if (eng_start) k <= 1;
    else if (k > 0) k <= k + 1;
    if (eng_start) begin
      ea <= eng_a;
      eb <= eng_b;
      if (mode != 1) eng_done <= 1'b0;
    end else if (k == 3 && mode != 2) begin
      eng_done   <= 1'b1;
      eng_result <= (mode == 1) ? 8'd7 : gcd_model(ea, eb);
    end else if (k == 1 && mode == 1) begin
      eng_done <= 1'b0;
    end
  end

  typedef struct {
    logic [W-1:0] a, b, res;
    logic         to;
    int           cyc;
  } rsp_t;
  rsp_t         rq[$];
  logic [W-1:0] sa[$], sb[$];
  int           starts = 0;
  int           start_cyc = 0;

  always @(negedge clk) begin
    if (eng_start) begin
      starts    <= starts + 1;
      start_cyc <= cyc;
      sa.push_back(eng_a);
      sb.push_back(eng_b);
    end
    if (rsp_valid && rsp_ready)
      rq.push_back('{a: rsp_a, b: rsp_b, res: rsp_result, to: rsp_timeout, cyc: cyc});
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int budget,
                      output logic ok);
    req_a = a; req_b = b; req_valid = 1'b1; ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string tag);
    int c = 0;
    while (rq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, rq.size(), n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_ab"}, {eng_a, eng_b}, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_fields"}, {rsp_result, rsp_a, rsp_b, rsp_timeout}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [W-1:0] t3_a[5]   = '{8, 9, 10, 25, 27};
  logic [W-1:0] t3_b[5]   = '{12, 6, 4, 15, 18};
  logic [W-1:0] t3_res[5] = '{4, 3, 2, 5, 9};

  initial begin
    logic ok;
    int s0, acc, c;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single operation
    push(8'd15, 8'd5, 10, ok);
    wait_rsp(1, 50, "t1_count");
    chk("t1_starts", starts, 1);
    chk("t1_eng_ab", {sa[0], sb[0]}, {8'd15, 8'd5});
    chk("t1_result", rq[0].res, 5);
    chk("t1_timeout", rq[0].to, 0);
    chk("t1_echo", {rq[0].a, rq[0].b}, {8'd15, 8'd5});
    rq.delete();

    // Back-to-back requests
    push(8'd15, 8'd6, 10, ok);
    push(8'd123, 8'd33, 10, ok);
    push(8'd124, 8'd33, 10, ok);
    wait_rsp(3, 100, "t2_count");
    @(negedge clk);
    chk("t2_res0", {rq[0].a, rq[0].res}, {8'd15, 8'd3});
    chk("t2_res1", {rq[1].a, rq[1].res}, {8'd123, 8'd3});
    chk("t2_res2", {rq[2].a, rq[2].res}, {8'd124, 8'd1});
    chk("t2_starts", starts, 4);
    chk("t2_busy", busy, 0);
    rq.delete();

    // Backpressure: 4 in FIFO plus 1 in flight, sixth refused
    s0 = starts;
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(t3_a[i], t3_b[i], 12, ok);
      if (ok) acc++;
    end
    push(8'd35, 8'd21, 12, ok);
    if (ok) acc++;
    chk("t3_accepted", acc, 5);
    chk("t3_req_ready", req_ready, 0);
    c = 0;
    while (!rsp_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", {rsp_valid, rsp_a, rsp_b, rsp_result, rsp_timeout},
          {1'b1, 8'd8, 8'd12, 8'd4, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_rsp(5, 150, "t3_count");
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      chk("t3_order", {rq[i].a, rq[i].b, rq[i].res}, {t3_a[i], t3_b[i], t3_res[i]});
    chk("t3_starts", starts - s0, 5);
    rq.delete();

    // Zero operands bypass the engine
    s0 = starts;
    push(8'd0, 8'd9, 10, ok);
    push(8'd0, 8'd0, 10, ok);
    wait_rsp(2, 50, "t4_count");
    @(negedge clk);
    chk("t4_res0", {rq[0].a, rq[0].b, rq[0].res}, {8'd0, 8'd9, 8'd9});
    chk("t4_res1", {rq[1].a, rq[1].b, rq[1].res}, {8'd0, 8'd0, 8'd0});
    chk("t4_no_start", starts - s0, 0);
    rq.delete();

    // Stale done from the previous operation must be ignored
    mode = 1;
    chk("t5_stale_done", eng_done, 1);
    push(8'd14, 8'd35, 10, ok);
    wait_rsp(1, 50, "t5_count");
    chk("t5_result", {rq[0].res, rq[0].to}, {8'd7, 1'b0});
    rq.delete();
    @(negedge clk);

    // Engine never completes: timeout after 15 wait cycles
    mode = 2;
    push(8'd12, 8'd18, 10, ok);
    wait_rsp(1, 80, "t6_count");
    chk("t6_timeout", {rq[0].to, rq[0].res}, {1'b1, 8'd0});
    chk("t6_echo", {rq[0].a, rq[0].b}, {8'd12, 8'd18});
    chk("t6_latency", rq[0].cyc - start_cyc, 16);
    rq.delete();
    @(negedge clk);

    // Reset during WAIT_HIGH with requests still buffered
    s0 = starts;
    push(8'd12, 8'd18, 10, ok);
    push(8'd3, 8'd6, 10, ok);
    push(8'd4, 8'd8, 10, ok);
    c = 0;
    while (starts == s0 && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("t7_started", starts - s0, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("t7_reset");
    reset = 1'b0;
    s0 = starts;
    repeat (8) @(negedge clk);
    chk("t7_no_start", starts - s0, 0);
    chk("t7_busy", busy, 0);
    chk("t7_no_rsp", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
